// File: rtl/mux_rr_arbiter_4x1.sv
// Four-source round-robin arbiter with a bounded hold time. It drives a registered
// one-hot grant and the 2-bit select for a downstream 4x1 mux.
module mux_rr_arbiter_4x1 #(
    parameter int MAX_HOLD = 4
) (
    input  logic       Clk_s,
    input  logic       Rst_s,
    input  logic [3:0] Req_s,
    output logic [3:0] Gnt_s,
    output logic       S1_s,
    output logic       S0_s,
    output logic       Valid_s,
    output logic [3:0] Hold_s
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t     state_q, state_d;
    logic [3:0] gnt_q, gnt_d;
    logic [1:0] sel_q, sel_d;
    logic       valid_q, valid_d;
    logic [3:0] hold_q, hold_d;
    logic [1:0] last_q, last_d;

    logic       issue;
    logic [1:0] winner;

    // Search begins just after the last winner, so the previous owner is tried last.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = last;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = last + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        valid_d = valid_q;
        hold_d  = hold_q;
        last_d  = last_q;
        issue   = 1'b0;
        winner  = rr_pick(Req_s, last_q);

        case (state_q)
            IDLE: begin
                issue = |Req_s;
            end
            GRANT: begin
                if (Req_s[last_q] && (hold_q < HOLD_LAST)) begin
                    hold_d = hold_q + 4'd1;
                end else if (|Req_s) begin
                    issue = 1'b1;
                end else begin
                    // The select keeps its last value so the downstream mux does not toggle.
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    valid_d = 1'b0;
                    hold_d  = 4'd0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue) begin
            state_d = GRANT;
            gnt_d   = 4'b0001 << winner;
            sel_d   = winner;
            valid_d = 1'b1;
            hold_d  = 4'd0;
            last_d  = winner;
        end
    end

    always_ff @(posedge Clk_s or negedge Rst_s) begin
        if (!Rst_s) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b00;
            valid_q <= 1'b0;
            hold_q  <= 4'd0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            valid_q <= valid_d;
            hold_q  <= hold_d;
            last_q  <= last_d;
        end
    end

    assign Gnt_s   = gnt_q;
    assign S1_s    = sel_q[1];
    assign S0_s    = sel_q[0];
    assign Valid_s = valid_q;
    assign Hold_s  = hold_q;

endmodule
